// File: rtl/serial_wide_comparator_if.sv
// Handshake and operand/result bundle for the nibble-serial magnitude comparator.
interface serial_wide_comparator_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cas_lt;
  logic             cas_gt;
  logic             cas_eq;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, a, b, cas_lt, cas_gt, cas_eq,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, a, b, cas_lt, cas_gt, cas_eq,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/serial_wide_comparator.sv
// Unsigned WIDTH-bit compare, one 4-bit cascade step per cycle, LSB nibble first.
// Result encoding on lt/gt/eq matches a 4-bit cascaded comparator stage.
module serial_wide_comparator #(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_wide_comparator_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IdxW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Result vectors are {lt, gt, eq}.
  logic [2:0]       r_res;
  logic [2:0]       r_out;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [2:0]       w_seed;
  logic [2:0]       w_step;

  always_comb begin
    w_accept = (r_state == StIdle) && bus.start;
    w_last   = (r_idx == IdxW'(NIBBLES - 1));
    w_a_nib  = r_a[3:0];
    w_b_nib  = r_b[3:0];

    // Seed normalised to one-hot, priority eq > gt > lt, all-zero treated as eq.
    if (bus.cas_eq)      w_seed = 3'b001;
    else if (bus.cas_gt) w_seed = 3'b010;
    else if (bus.cas_lt) w_seed = 3'b100;
    else                 w_seed = 3'b001;

    if (w_a_nib > w_b_nib)      w_step = 3'b010;
    else if (w_a_nib < w_b_nib) w_step = 3'b100;
    else                        w_step = r_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun:   if (w_last)    w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == StRun);
    bus.done = r_done;
    bus.lt   = r_out[2];
    bus.gt   = r_out[1];
    bus.eq   = r_out[0];
  end

  // Operands shift right so the active nibble is always in [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= 3'b000;
      r_out  <= 3'b000;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_idx <= '0;
        r_res <= w_seed;
      end else if (r_state == StRun) begin
        r_a   <= r_a >> 4;
        r_b   <= r_b >> 4;
        r_res <= w_step;
        r_idx <= r_idx + IdxW'(1);
        if (w_last) begin
          r_out  <= w_step;
          r_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_wide_comparator.sv
// Scoreboard bench: a cycle model of the handshake predicts busy/done/result for the
// 16-bit instance; a 4-bit instance is checked directly.
module tb_serial_wide_comparator;
  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic armed = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  serial_wide_comparator_if #(.WIDTH(W)) bus16 ();
  serial_wide_comparator_if #(.WIDTH(4)) bus4 ();

  serial_wide_comparator #(.WIDTH(W)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_wide_comparator #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full-width unsigned compare, seed only decides on equality.
  function automatic logic [2:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic l, input logic g, input logic e);
    if (a > b) return 3'b010;
    if (a < b) return 3'b100;
    if (e)     return 3'b001;
    if (g)     return 3'b010;
    if (l)     return 3'b100;
    return 3'b001;
  endfunction

  logic [2:0] q[$];
  int         m_cnt  = 0;
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      q.delete();
    end else begin
      m_done <= (m_cnt == 1);
      if (m_cnt == 1 && q.size() > 0) m_res <= q.pop_front();
      if (m_cnt == 0 && bus16.start) begin
        q.push_back(exp_res(bus16.a, bus16.b, bus16.cas_lt, bus16.cas_gt, bus16.cas_eq));
        m_cnt <= NIB;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(bus16.busy), 32'(m_cnt != 0));
      chk("done", 32'(bus16.done), 32'(m_done));
      chk("result", 32'({bus16.lt, bus16.gt, bus16.eq}), 32'(m_res));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] lge);
    bus16.start  = 1'b1;
    bus16.a      = a;
    bus16.b      = b;
    bus16.cas_lt = lge[2];
    bus16.cas_gt = lge[1];
    bus16.cas_eq = lge[0];
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] lge);
    @(posedge clk); #1;
    drive(a, b, lge);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (NIB) @(posedge clk);
  endtask

  initial begin
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus16.cas_lt = 1'b0; bus16.cas_gt = 1'b0; bus16.cas_eq = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus4.cas_lt = 1'b0; bus4.cas_gt = 1'b0; bus4.cas_eq = 1'b0;
    #1 rst_n = 1'b0;
    #1 armed = 1'b1;
    chk("rst_out", 32'({bus16.lt, bus16.gt, bus16.eq, bus16.busy, bus16.done}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    launch(16'h1234, 16'h1235, 3'b001);
    launch(16'hA000, 16'h0FFF, 3'b001);
    launch(16'h6666, 16'h6666, 3'b010);
    launch(16'h6666, 16'h6666, 3'b100);
    launch(16'h6666, 16'h6666, 3'b110);
    launch(16'h6666, 16'h6666, 3'b000);
    launch(16'h6666, 16'h6666, 3'b111);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      ra = W'($urandom);
      launch(ra, (i % 2 == 0) ? ra : W'($urandom), 3'($urandom_range(0, 7)));
    end

    // Back-to-back: start held high.
    @(posedge clk); #1;
    drive(16'h0001, 16'h0002, 3'b001);
    repeat (3 * NIB) @(posedge clk);
    #1 bus16.start = 1'b0;
    repeat (NIB + 2) @(posedge clk);

    // Operand change and extra start mid-RUN.
    @(posedge clk); #1;
    drive(16'h0001, 16'h0002, 3'b001);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    drive(16'hFFFF, 16'h0000, 3'b010);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (NIB) @(posedge clk);
    chk("midrun_lt", 32'({bus16.lt, bus16.gt, bus16.eq}), 32'h4);

    // Reset during cycle 2 of RUN.
    @(posedge clk); #1;
    drive(16'h0001, 16'h0002, 3'b001);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort", 32'({bus16.lt, bus16.gt, bus16.eq, bus16.busy, bus16.done}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    launch(16'h8001, 16'h8000, 3'b100);

    // 4-bit instance: single-cycle RUN.
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.a = 4'h5; bus4.b = 4'h2; bus4.cas_eq = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    chk("w4_busy", 32'({bus4.busy, bus4.done}), 32'h2);
    @(posedge clk); #1;
    chk("w4_done", 32'({bus4.busy, bus4.done}), 32'h1);
    chk("w4_gt", 32'({bus4.lt, bus4.gt, bus4.eq}), 32'h2);
    @(posedge clk); #1;
    chk("w4_pulse", 32'(bus4.done), 32'h0);

    repeat (2) @(posedge clk);
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
